// File: rtl/vector_load_unit_pkg.sv
// vector_load_unit_pkg
// Shared constants for the vector load unit and its neighbours:
//   - FSM state encodings (3-bit, legacy-compatible localparams)
//   - D-register position codes
//   - word / address widths
//   - register file source-select codes
// No ports; imported with "import vector_load_unit_pkg::*;".
package vector_load_unit_pkg;

  // Word and address widths of the register file / data memory path
  localparam int VLU_WORD_W = 32;
  localparam int VLU_ADDR_W = 32;
  localparam int VLU_WORDS  = 4;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  // D-register position codes; 3 is not a register
  localparam logic [1:0] POS_D1      = 2'd0;
  localparam logic [1:0] POS_D2      = 2'd1;
  localparam logic [1:0] POS_D3      = 2'd2;
  localparam logic [1:0] POS_ILLEGAL = 2'd3;

  // Register file write-port source-select codes
  localparam logic [1:0] RF_SRC_ALU = 2'd0;
  localparam logic [1:0] RF_SRC_VLU = 2'd1;
  localparam logic [1:0] RF_SRC_IMM = 2'd2;

endpackage

// File: rtl/vector_load_unit_word_buffer.sv
// vlu_word_buffer
// Four DATA_W-bit capture registers written one at a time by index.
// o_flat presents word 0 in the top bits (D[127:96]) down to word 3.
// The word being written this cycle is forwarded onto o_flat so the
// owner can snapshot a complete vector on the same edge that captures
// the final word.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_we           : write enable
//   i_idx          : word index to write (0..3)
//   i_wdata        : word to capture
//   o_flat         : 4*DATA_W flat view, word 0 in the MSBs
module vlu_word_buffer #(
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_we,
  input  logic [1:0]            i_idx,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [4*DATA_W-1:0]   o_flat
);

  logic [DATA_W-1:0] r_word [4];
  logic [DATA_W-1:0] w_view [4];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 4; i++) r_word[i] <= '0;
    end else if (i_we) begin
      r_word[i_idx] <= i_wdata;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_view[i] = r_word[i];
      if (i_we && (i_idx == 2'(i))) w_view[i] = i_wdata;
    end
  end

  assign o_flat = {w_view[0], w_view[1], w_view[2], w_view[3]};

endmodule

// File: rtl/vector_load_unit.sv
// vector_load_unit
// Fetches four consecutive words from data memory starting at a base
// address, assembles them into data0..data3 and issues a one-cycle
// reg_write so the register file loads one full 128-bit D register.
// Optional build macro: VLU_ALIGN_CHECK_EN -- when defined, a start
// with base_addr[3:0] != 0 is rejected (done+err, no memory traffic).
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_start               : load request, accepted only in IDLE
//   i_base_addr           : byte address of word 0
//   i_dest_pos            : target register 0:D1 1:D2 2:D3 (3 illegal)
//   o_busy, o_done, o_err : status; done/err are single-cycle pulses
//   o_mem_req/o_mem_addr  : read request and address
//   i_mem_gnt             : request accepted when mem_req & mem_gnt
//   i_mem_rvalid/rdata    : read response
//   o_data0..o_data3      : assembled words (data0 -> D[127:96])
//   o_data_pos            : destination register for the write
//   o_reg_write           : register file write strobe
//   o_dbg_state           : current FSM state
// Memory handshake: a request is transferred on a cycle where mem_req
// and mem_gnt are both high; mem_addr is held unchanged until then. Only
// one request is ever outstanding; its response is the first mem_rvalid
// seen in WAIT, and rvalid in any other state is discarded.
module vector_load_unit
  import vector_load_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRIDE = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [1:0]        i_dest_pos,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_data0,
  output logic [DATA_W-1:0] o_data1,
  output logic [DATA_W-1:0] o_data2,
  output logic [DATA_W-1:0] o_data3,
  output logic [1:0]        o_data_pos,
  output logic              o_reg_write,
  output logic [2:0]        o_dbg_state
);

  logic [2:0]          r_state;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [1:0]          r_dest_q;
  logic [1:0]          r_cnt;
  logic [DATA_W-1:0]   r_data [4];
  logic [1:0]          r_data_pos;

  logic                w_reject;
  logic                w_capture;
  logic [ADDR_W-1:0]   w_offset;
  logic [4*DATA_W-1:0] w_flat;

`ifdef VLU_ALIGN_CHECK_EN
  assign w_reject = (i_dest_pos == POS_ILLEGAL) || (i_base_addr[3:0] != 4'd0);
`else
  assign w_reject = (i_dest_pos == POS_ILLEGAL);
`endif

  // Offset wraps modulo 2^ADDR_W together with the addition below
  assign w_offset  = ADDR_W'(STRIDE) * {{(ADDR_W-2){1'b0}}, r_cnt};
  assign w_capture = (r_state == ST_WAIT) && i_mem_rvalid;

  vlu_word_buffer #(.DATA_W(DATA_W)) u_buf (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (w_capture),
    .i_idx   (r_cnt),
    .i_wdata (i_mem_rdata),
    .o_flat  (w_flat)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_addr_q   <= '0;
      r_dest_q   <= '0;
      r_cnt      <= '0;
      r_data_pos <= '0;
      for (int i = 0; i < 4; i++) r_data[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_addr_q <= i_base_addr;
            r_dest_q <= i_dest_pos;
            r_cnt    <= 2'd0;
            r_state  <= w_reject ? ST_ERR : ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_mem_gnt) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_mem_rvalid) begin
            if (r_cnt == 2'd3) begin
              // Output words only change here, so a partial vector is never visible
              for (int i = 0; i < 4; i++)
                r_data[i] <= w_flat[(4-i)*DATA_W-1 -: DATA_W];
              r_data_pos <= r_dest_q;
              r_state    <= ST_WRITE;
            end else begin
              r_cnt   <= r_cnt + 2'd1;
              r_state <= ST_REQ;
            end
          end
        end
        ST_WRITE: r_state <= ST_IDLE;
        ST_ERR:   r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_WRITE) || (r_state == ST_ERR);
  assign o_err       = (r_state == ST_ERR);
  assign o_mem_req   = (r_state == ST_REQ);
  assign o_mem_addr  = o_mem_req ? (r_addr_q + w_offset) : '0;
  assign o_reg_write = (r_state == ST_WRITE);
  assign o_data0     = r_data[0];
  assign o_data1     = r_data[1];
  assign o_data2     = r_data[2];
  assign o_data3     = r_data[3];
  assign o_data_pos  = r_data_pos;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vector_load_unit.sv
// tb_vector_load_unit
// Directed bench for vector_load_unit: a small memory responder with
// programmable grant stall / rvalid delay, an expected-address queue,
// and hand-chosen vectors covering normal loads, stalls, ignored
// start/rvalid, illegal destination, alignment, wrap and mid-run reset.
module tb_vector_load_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [1:0]  dest_pos;
  logic        busy, done, err, mem_req, reg_write;
  logic [31:0] mem_addr;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] data0, data1, data2, data3;
  logic [1:0]  data_pos;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Data the output registers must still hold from the previous write
  logic [31:0] last_d [4];
  logic [1:0]  last_pos;

  vector_load_unit dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_base_addr  (base_addr),
    .i_dest_pos   (dest_pos),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .i_mem_gnt    (mem_gnt),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata),
    .o_data0      (data0),
    .o_data1      (data1),
    .o_data2      (data2),
    .o_data3      (data3),
    .o_data_pos   (data_pos),
    .o_reg_write  (reg_write),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory contents: the first test window holds 0x11..0x44, elsewhere a
  // pattern derived from the address so word order errors are visible.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_fn = 32'h0000_0011;
      32'h0000_0104: mem_fn = 32'h0000_0022;
      32'h0000_0108: mem_fn = 32'h0000_0033;
      32'h0000_010C: mem_fn = 32'h0000_0044;
      default:       mem_fn = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  task automatic idle_inputs();
    start      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  // ---------------- driver / responder ----------------
  // Called at a negedge. Drives start, then acts as the memory until done
  // (or until the planned reset abort), checking every requested address.
  task automatic run_load(input logic [31:0] base, input logic [1:0] pos,
                          input int stall_word, input int gnt_stall, input int rv_dly,
                          input bit noise, input int abort_word,
                          input bit exp_err, input int exp_lat);
    logic [31:0] exp_q[$];
    logic [31:0] exp_d [4];
    logic [31:0] pend_addr;
    int widx, stall_left, wait_left, n_done, n_wr, n_req, k, done_k;
    bit pending, finished, aborted, noise_done;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(base + 32'(4 * i));
      exp_d[i] = mem_fn(base + 32'(4 * i));
    end
    widx = 0; pending = 0; finished = 0; aborted = 0; noise_done = 0;
    stall_left = (stall_word == 0) ? gnt_stall : 0;
    wait_left = 0; n_done = 0; n_wr = 0; n_req = 0; k = 0; done_k = -1;
    pend_addr = '0;
    idle_inputs();
    start = 1'b1; base_addr = base; dest_pos = pos;
    while (!finished) begin
      @(negedge clk);
      k++;
      idle_inputs();
      if (noise && k == 3) begin
        start = 1'b1; base_addr = 32'h0000_0F00; dest_pos = 2'd0;
      end
      if (reg_write) n_wr++;
      if (mem_req) n_req++;
      if (done) begin
        n_done++; done_k = k; finished = 1;
        check_eq("done_busy", busy, 1'b1);
        check_eq("done_err", err, exp_err);
        check_eq("done_reg_write", reg_write, !exp_err);
        if (!exp_err) begin
          check_eq("data0", data0, exp_d[0]);
          check_eq("data1", data1, exp_d[1]);
          check_eq("data2", data2, exp_d[2]);
          check_eq("data3", data3, exp_d[3]);
          check_eq("data_pos", data_pos, pos);
        end else begin
          check_eq("err_data0_held", data0, last_d[0]);
          check_eq("err_data3_held", data3, last_d[3]);
          check_eq("err_pos_held", data_pos, last_pos);
        end
      end else if (mem_req) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_mem_req", mem_addr, 32'hFFFF_FFFF);
        end else begin
          check_eq("mem_addr", mem_addr, exp_q[0]);
          if (noise && widx == 1 && !noise_done) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0; noise_done = 1;
          end
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            mem_gnt = 1'b1;
            pend_addr = mem_addr;
            void'(exp_q.pop_front());
            pending = 1;
            wait_left = (widx == stall_word) ? rv_dly : 0;
          end
        end
      end else if (pending) begin
        if (wait_left > 0) begin
          wait_left--;
        end else if (widx == abort_word) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          check_eq("abort_busy", busy, 1'b0);
          check_eq("abort_done", done, 1'b0);
          check_eq("abort_mem_req", mem_req, 1'b0);
          check_eq("abort_mem_addr", mem_addr, 32'h0);
          check_eq("abort_reg_write", reg_write, 1'b0);
          check_eq("abort_data0", data0, 32'h0);
          check_eq("abort_data_pos", data_pos, 2'd0);
          // late response for the aborted request
          mem_rvalid = 1'b1; mem_rdata = mem_fn(pend_addr);
          for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle_inputs();
            if (done) n_done++;
            if (reg_write) n_wr++;
            if (mem_req) n_req++;
          end
          check_eq("late_rvalid_busy", busy, 1'b0);
          check_eq("late_rvalid_data1", data1, 32'h0);
          check_eq("abort_no_done", n_done, 0);
          check_eq("abort_no_write", n_wr, 0);
          for (int i = 0; i < 4; i++) last_d[i] = '0;
          last_pos = '0;
          aborted = 1; finished = 1;
        end else begin
          mem_rvalid = 1'b1;
          mem_rdata = mem_fn(pend_addr);
          pending = 0;
          widx++;
          stall_left = (widx == stall_word) ? gnt_stall : 0;
        end
      end
      if (!finished && k > 80) begin
        check_eq("timeout", k, exp_lat);
        finished = 1;
      end
    end
    if (!aborted) begin
      check_eq("latency", done_k, exp_lat);
      // a few idle cycles: no second done, no queued start
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        idle_inputs();
        if (done) n_done++;
        if (mem_req) n_req++;
        if (reg_write) n_wr++;
      end
      check_eq("one_done", n_done, 1);
      check_eq("idle_after", busy, 1'b0);
      check_eq("write_count", n_wr, exp_err ? 0 : 1);
      if (exp_err) check_eq("no_mem_req", n_req, 0);
      else         check_eq("all_words_granted", exp_q.size(), 0);
      if (!exp_err) begin
        for (int i = 0; i < 4; i++) last_d[i] = exp_d[i];
        last_pos = pos;
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    base_addr = '0; dest_pos = '0;
    idle_inputs();
    for (int i = 0; i < 4; i++) last_d[i] = '0;
    last_pos = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_reg_write", reg_write, 1'b0);
    check_eq("rst_data0", data0, 32'h0);
    check_eq("rst_data2", data2, 32'h0);
    check_eq("rst_data_pos", data_pos, 2'd0);
    @(negedge clk);

    // zero-wait load into D2: 0x11..0x44 at T+9
    run_load(32'h0000_0100, 2'd1, -1, 0, 0, 0, -1, 0, 9);
    // gnt stall of 2 and rvalid delay of 3 on word 2: five cycles later
    run_load(32'h0000_0200, 2'd2, 2, 2, 3, 0, -1, 0, 14);
    // start while busy and a spurious rvalid in REQ are both ignored
    run_load(32'h0000_0300, 2'd0, -1, 0, 0, 1, -1, 0, 9);
    // illegal destination: done+err at T+1, data outputs held
    run_load(32'h0000_0400, 2'd3, -1, 0, 0, 0, -1, 1, 1);
    // misaligned base
`ifdef VLU_ALIGN_CHECK_EN
    run_load(32'h0000_0104, 2'd0, -1, 0, 0, 0, -1, 1, 1);
`else
    run_load(32'h0000_0104, 2'd0, -1, 0, 0, 0, -1, 0, 9);
`endif
    // address wrap: FFFFFFF8, FFFFFFFC, 0, 4
    run_load(32'hFFFF_FFF8, 2'd2, -1, 0, 0, 0, -1, 0, 9);
    // reset in WAIT of word 2, late rvalid ignored
    run_load(32'h0000_0500, 2'd1, -1, 0, 0, 0, 2, 0, 0);
    // the unit still works normally after the abort
    run_load(32'h0000_0600, 2'd0, 1, 1, 1, 0, -1, 0, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
